ecd_row_receiver: RTL and testbench
===================================

# ecd_row_receiver

Receives row data returned by ECD_Master in answer to the row-requests issued by the request generator, then checks framing and row sequence. Passes each beat downstream through a 2-entry skid buffer. Returns a one-cycle `row_complete` pulse per well-framed row; this pulse drives the request generator's `row_complete_in` to keep its outstanding-request window moving. Sits directly between the ECD_Master row-data stream and the downstream data sink.

## Interface

**Parameters**
- `DATA_WIDTH`, 256: width of the row-data stream in bits.
- `ROW_BEATS`, 32: beats per row, header beat included; legal range 2..65535.
- `START_TAG`, 32'h0000_C008: expected header tag of the first row after `sync_in`.

**Ports**
- `clk`, in, 1: the only clock. All logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `sync_in`, in, 1: one-cycle pulse. Restarts the sequence check and the row count. It is driven by the same strobe that starts the request generator.
- `clear_errors`, in, 1: one-cycle pulse. Clears both sticky error flags.
- `AXIS_RX_TDATA`, in, DATA_WIDTH: row data from ECD_Master. Beat 0 of each row is the header; its bits [31:0] hold the row tag.
- `AXIS_RX_TVALID`, in, 1: input beat valid.
- `AXIS_RX_TLAST`, in, 1: marks the last beat of a row.
- `AXIS_RX_TREADY`, out, 1: this block can accept an input beat.
- `AXIS_TX_TDATA`, out, DATA_WIDTH: forwarded beat, bit-identical to the input beat.
- `AXIS_TX_TVALID`, out, 1: output beat valid.
- `AXIS_TX_TLAST`, out, 1: forwarded TLAST.
- `AXIS_TX_TREADY`, in, 1: downstream can accept a beat.
- `row_complete`, out, 1: one-cycle pulse for each well-framed row.
- `rows_received`, out, 32: count of well-framed rows since the last `sync_in` or reset. Wraps modulo 2^32.
- `err_framing`, out, 1: sticky flag. Set when TLAST arrives early or late.
- `err_sequence`, out, 1: sticky flag. Set on a header tag mismatch.

## Operation

**Acceptance.** An input beat is accepted when `AXIS_RX_TVALID & AXIS_RX_TREADY`.

**Beat counter.** `beat_cnt` is 16 bits and counts the current row's beats from 0 to ROW_BEATS-1.

**Header beat.** This is the beat accepted when `beat_cnt == 0`.
- If TDATA[31:0] is not equal to `expected_tag`, set `err_sequence`.
- In either case, load `expected_tag` with TDATA[31:0] + 1. This resynchronises the check, so a single gap gives a single error.

**Row end.** The row ends on whichever of these happens first: TLAST is accepted, or the beat at `beat_cnt == ROW_BEATS-1` is accepted. At row end, `beat_cnt` returns to 0. The row is handled as follows:
- **Well-framed:** TLAST is set and `beat_cnt == ROW_BEATS-1`. Pulse `row_complete` and increment `rows_received`.
- **Early:** TLAST is set and `beat_cnt < ROW_BEATS-1`. Set `err_framing`. No pulse and no count.
- **Late:** TLAST is clear at `beat_cnt == ROW_BEATS-1`. Set `err_framing`. No pulse and no count. The next beat is treated as a header.

**Skid buffer.** All beats are forwarded unchanged, including those of errored rows. Forwarding uses a 2-entry skid buffer with states EMPTY, ONE and FULL.
- EMPTY to ONE: input accepted, no output taken.
- ONE to FULL: input accepted, no output taken.
- ONE to EMPTY: output taken, no input.
- FULL to ONE: output taken.
- ONE stays ONE: input and output in the same cycle.
- Order is strictly FIFO. The buffer never drops or duplicates a beat.

**`sync_in`.**
- Loads `expected_tag` with START_TAG and clears `rows_received`.
- Does not touch `beat_cnt`, the skid buffer or the error flags.
- If `sync_in` coincides with a header beat, the header is compared against START_TAG.
- If `sync_in` coincides with a well-framed row end, the row still pulses `row_complete`, but `rows_received` becomes 0.

**`clear_errors`.** Clears both flags. If an error is detected in the same cycle, the flag ends up set.

**Reset.**
- Outputs: `AXIS_RX_TREADY`, `AXIS_TX_TVALID`, `AXIS_TX_TLAST`, `row_complete`, `err_framing`, `err_sequence` = 0; `rows_received` = 0; `AXIS_TX_TDATA` = 0.
- Internal state: `beat_cnt` = 0, `expected_tag` = START_TAG, skid buffer EMPTY.
- Reset mid-row discards any buffered beats and any partial-row state.

## Timing

- **`AXIS_RX_TREADY`:** registered; high whenever the buffer is not FULL. It goes high on the first `clk` edge after `reset` is released.
- **Forwarding latency:** 1 cycle from input acceptance to `AXIS_TX_TVALID`.
- **Throughput:** 1 beat per clock while `AXIS_TX_TREADY` stays high.
- **Output stability:** `AXIS_TX_TVALID`, `AXIS_TX_TDATA` and `AXIS_TX_TLAST` are held stable until accepted. `AXIS_TX_TVALID` never depends combinationally on `AXIS_TX_TREADY`.
- **`row_complete` and `rows_received`:** both update on the cycle after the final beat is accepted. The pulse lasts exactly 1 cycle.
- **Back-to-back rows:** give one pulse per row, with the pulses ROW_BEATS cycles apart at full rate.
- **Error flags:** assert on the cycle after the offending beat is accepted.

## Test plan

1. **Clean rows.** ROW_BEATS=4, `sync_in`, then 3 rows with tags C008, C009, C00A, TLAST on beat 3 and TX_TREADY=1.
   - Expect 3 `row_complete` pulses, each 1 cycle after its beat 3.
   - Expect `rows_received`=3, both error flags 0.
   - Expect the output beat stream identical to the input, with 1-cycle latency.
2. **Backpressure.** Hold TX_TREADY=0 while 5 beats are offered.
   - Expect exactly 2 beats accepted, then RX_TREADY=0.
   - After releasing TX_TREADY, expect all 5 beats out in order, none lost or duplicated.
3. **Framing errors.**
   - TLAST on beat 1 of 4: expect `err_framing`=1, no pulse, next beat treated as a header.
   - A 4-beat row without TLAST: expect `err_framing`=1, no pulse.
   - `clear_errors` afterwards: expect the flag back to 0.
4. **Sequence error.** Tags C008, C00A, C00B.
   - Expect `err_sequence` to set once, on C00A.
   - Expect 3 pulses and `rows_received`=3.
5. **Simultaneous events.**
   - `sync_in` on a well-framed row end: expect the pulse plus `rows_received`=0.
   - `clear_errors` together with a framing error: expect `err_framing`=1.
6. **Reset mid-row.** Assert `reset` after beat 2 with the buffer FULL.
   - Expect all outputs at their reset values asynchronously.
   - After release, a clean row tagged C008 gives `row_complete` and no errors.

Source files
------------

// File: rtl/ecd_row_receiver.sv
// ecd_row_receiver: checks framing and header-tag sequence of the ECD_Master
// row-data stream and forwards every beat through a 2-entry skid buffer.
module ecd_row_receiver #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ROW_BEATS  = 32,
  parameter logic [31:0] START_TAG  = 32'h0000_C008
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sync_in,
  input  logic                  clear_errors,
  input  logic [DATA_WIDTH-1:0] AXIS_RX_TDATA,
  input  logic                  AXIS_RX_TVALID,
  input  logic                  AXIS_RX_TLAST,
  output logic                  AXIS_RX_TREADY,
  output logic [DATA_WIDTH-1:0] AXIS_TX_TDATA,
  output logic                  AXIS_TX_TVALID,
  output logic                  AXIS_TX_TLAST,
  input  logic                  AXIS_TX_TREADY,
  output logic                  row_complete,
  output logic [31:0]           rows_received,
  output logic                  err_framing,
  output logic                  err_sequence
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ROW_BEATS - 1);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t;

  skid_state_t           state, state_nxt;
  logic                  load_head_in, load_head_skid, load_skid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  skid_last;

  logic                  in_acc, out_acc;
  logic [CNT_W-1:0]      beat_cnt;
  logic [31:0]           expected_tag;
  logic                  is_header, at_last_beat, row_end;
  logic                  well_framed, framing_hit, sequence_hit;
  logic [31:0]           tag_cmp;

  assign in_acc  = AXIS_RX_TVALID & AXIS_RX_TREADY;
  assign out_acc = AXIS_TX_TVALID & AXIS_TX_TREADY;

  // Skid buffer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Skid buffer next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (in_acc) state_nxt = ONE;
      ONE: begin
        if (in_acc && !out_acc)      state_nxt = FULL;
        else if (!in_acc && out_acc) state_nxt = EMPTY;
      end
      FULL:    if (out_acc) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Skid buffer datapath controls
  always_comb begin
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state)
      EMPTY: load_head_in = in_acc;
      ONE: begin
        load_head_in = in_acc & out_acc;
        load_skid    = in_acc & ~out_acc;
      end
      FULL:    load_head_skid = out_acc;
      default: ;
    endcase
  end

  // Head (output) and skid registers, valid/ready flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      AXIS_TX_TDATA  <= '0;
      AXIS_TX_TLAST  <= 1'b0;
      AXIS_TX_TVALID <= 1'b0;
      AXIS_RX_TREADY <= 1'b0;
      skid_data      <= '0;
      skid_last      <= 1'b0;
    end else begin
      AXIS_TX_TVALID <= (state_nxt != EMPTY);
      AXIS_RX_TREADY <= (state_nxt != FULL);
      if (load_head_in) begin
        AXIS_TX_TDATA <= AXIS_RX_TDATA;
        AXIS_TX_TLAST <= AXIS_RX_TLAST;
      end else if (load_head_skid) begin
        AXIS_TX_TDATA <= skid_data;
        AXIS_TX_TLAST <= skid_last;
      end
      if (load_skid) begin
        skid_data <= AXIS_RX_TDATA;
        skid_last <= AXIS_RX_TLAST;
      end
    end
  end

  // Row framing and header-tag classification of the accepted beat
  always_comb begin
    is_header    = (beat_cnt == '0);
    at_last_beat = (beat_cnt == LAST_BEAT);
    tag_cmp      = sync_in ? START_TAG : expected_tag;
    row_end      = in_acc & (AXIS_RX_TLAST | at_last_beat);
    well_framed  = in_acc & AXIS_RX_TLAST & at_last_beat;
    framing_hit  = in_acc & (AXIS_RX_TLAST ^ at_last_beat);
    sequence_hit = in_acc & is_header & (AXIS_RX_TDATA[31:0] != tag_cmp);
  end

  // Beat counter, tag tracker, row counter and sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt      <= '0;
      expected_tag  <= START_TAG;
      rows_received <= '0;
      row_complete  <= 1'b0;
      err_framing   <= 1'b0;
      err_sequence  <= 1'b0;
    end else begin
      if (row_end)     beat_cnt <= '0;
      else if (in_acc) beat_cnt <= beat_cnt + CNT_W'(1);

      if (in_acc && is_header) expected_tag <= AXIS_RX_TDATA[31:0] + 32'd1;
      else if (sync_in)        expected_tag <= START_TAG;

      if (sync_in)          rows_received <= '0;
      else if (well_framed) rows_received <= rows_received + 32'd1;

      row_complete <= well_framed;
      err_framing  <= (err_framing  & ~clear_errors) | framing_hit;
      err_sequence <= (err_sequence & ~clear_errors) | sequence_hit;
    end
  end

endmodule

// File: tb/tb_ecd_row_receiver.sv
// tb_ecd_row_receiver: directed stimulus with a beat scoreboard and pulse monitor.
module tb_ecd_row_receiver;

  localparam int unsigned DW = 64;
  localparam int unsigned RB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sync_in = 1'b0;
  logic          clear_errors = 1'b0;
  logic [DW-1:0] rx_tdata = '0;
  logic          rx_tvalid = 1'b0;
  logic          rx_tlast = 1'b0;
  logic          rx_tready;
  logic [DW-1:0] tx_tdata;
  logic          tx_tvalid;
  logic          tx_tlast;
  logic          tx_tready = 1'b1;
  logic          row_complete;
  logic [31:0]   rows_received;
  logic          err_framing;
  logic          err_sequence;

  ecd_row_receiver #(
    .DATA_WIDTH(DW),
    .ROW_BEATS (RB),
    .START_TAG (32'h0000_C008)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sync_in       (sync_in),
    .clear_errors  (clear_errors),
    .AXIS_RX_TDATA (rx_tdata),
    .AXIS_RX_TVALID(rx_tvalid),
    .AXIS_RX_TLAST (rx_tlast),
    .AXIS_RX_TREADY(rx_tready),
    .AXIS_TX_TDATA (tx_tdata),
    .AXIS_TX_TVALID(tx_tvalid),
    .AXIS_TX_TLAST (tx_tlast),
    .AXIS_TX_TREADY(tx_tready),
    .row_complete  (row_complete),
    .rows_received (rows_received),
    .err_framing   (err_framing),
    .err_sequence  (err_sequence)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    beat_id = 0;
  int    n_acc = 0;
  int    pulse_cnt = 0;
  logic  rc_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: pops the scoreboard on every forwarded beat, checks pulse width
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_tvalid && tx_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL fwd_extra actual=%0h expected=none", tx_tdata);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (tx_tdata !== e.data || tx_tlast !== e.last) begin
            failures++;
            $display("FAIL fwd_beat actual=%0h/%0b expected=%0h/%0b",
                     tx_tdata, tx_tlast, e.data, e.last);
          end
        end
      end
      if (row_complete) begin
        pulse_cnt++;
        checks++;
        if (rc_prev) begin
          failures++;
          $display("FAIL pulse_width actual=2+ cycles expected=1 cycle");
        end
      end
      rc_prev = row_complete;
    end else begin
      rc_prev = 1'b0;
    end
  end

  // Offer one beat; returns #1 after the accepting edge
  task automatic send_beat(input logic [31:0] lo, input logic last,
                           input logic sy, input logic clr);
    logic [DW-1:0] d;
    logic          acc;
    int            waited;
    d = {32'(beat_id), lo};
    beat_id++;
    rx_tdata = d; rx_tvalid = 1'b1; rx_tlast = last;
    sync_in = sy; clear_errors = clr;
    acc = 1'b0; waited = 0;
    while (!acc && waited < 20) begin
      @(negedge clk);
      if (rx_tready) begin
        acc = 1'b1;
        exp_q.push_back('{d, last});
        n_acc++;
      end
      @(posedge clk);
      waited++;
    end
    #1;
    rx_tvalid = 1'b0; rx_tlast = 1'b0; sync_in = 1'b0; clear_errors = 1'b0;
    if (!acc) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=not_accepted expected=accepted beat=%0h", d);
    end else if (tx_tready) begin
      check("fwd_latency", 64'(tx_tdata), 64'(d));
    end
  endtask

  // Row of RB beats with TLAST at position lastpos (RB means none)
  task automatic send_row(input logic [31:0] tag, input int lastpos, input logic sy_last);
    for (int k = 0; k < int'(RB); k++) begin
      send_beat((k == 0) ? tag : (32'hF000_0000 | 32'(k)), k == lastpos,
                sy_last && (k == int'(RB) - 1), 1'b0);
      if (k == lastpos) break;
    end
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    @(posedge clk); #1;
    clear_errors = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_tready", 64'(rx_tready), 64'd0);
    check("rst_tx_tvalid", 64'(tx_tvalid), 64'd0);
    check("rst_rows", 64'(rows_received), 64'd0);
    check("rst_errs", 64'({err_framing, err_sequence, row_complete}), 64'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("rx_tready_after_rst", 64'(rx_tready), 64'd1);

    // 1: clean back-to-back rows
    sync_in = 1'b1; @(posedge clk); #1; sync_in = 1'b0;
    send_row(32'h0000_C008, 3, 1'b0);
    check("t1_pulse0", 64'(row_complete), 64'd1);
    send_row(32'h0000_C009, 3, 1'b0);
    check("t1_pulse1", 64'(row_complete), 64'd1);
    send_row(32'h0000_C00A, 3, 1'b0);
    check("t1_pulse2", 64'(row_complete), 64'd1);
    check("t1_rows", 64'(rows_received), 64'd3);
    check("t1_errs", 64'({err_framing, err_sequence}), 64'd0);

    // 2: backpressure
    @(posedge clk); #1;
    tx_tready = 1'b0;
    acc0 = n_acc;
    send_beat(32'h0000_C00B, 1'b0, 1'b0, 1'b0);
    send_beat(32'hF000_0001, 1'b0, 1'b0, 1'b0);
    rx_tdata = 64'h1234_5678_9ABC_DEF0; rx_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_rx_stalled", 64'(rx_tready), 64'd0);
    end
    @(posedge clk); #1;
    rx_tvalid = 1'b0;
    check("t2_accepted", 64'(n_acc - acc0), 64'd2);
    tx_tready = 1'b1;
    send_beat(32'hF000_0002, 1'b0, 1'b0, 1'b0);
    send_beat(32'hF000_0003, 1'b1, 1'b0, 1'b0);
    check("t2_pulse", 64'(row_complete), 64'd1);
    send_row(32'h0000_C00C, 3, 1'b0);
    repeat (4) @(posedge clk); #1;
    check("t2_drained", 64'(exp_q.size()), 64'd0);
    check("t2_rows", 64'(rows_received), 64'd5);

    // 3: framing errors (early, then late)
    send_row(32'h0000_C00D, 1, 1'b0);
    check("t3_early_pulse", 64'(row_complete), 64'd0);
    check("t3_early_flag", 64'(err_framing), 64'd1);
    pulse_clear();
    check("t3_clear1", 64'(err_framing), 64'd0);
    send_row(32'h0000_C00E, int'(RB), 1'b0);
    check("t3_late_pulse", 64'(row_complete), 64'd0);
    check("t3_late_flag", 64'(err_framing), 64'd1);
    check("t3_hdr_resync", 64'(err_sequence), 64'd0);
    check("t3_rows", 64'(rows_received), 64'd5);
    pulse_clear();
    check("t3_clear2", 64'(err_framing), 64'd0);

    // 4: sequence error
    sync_in = 1'b1; @(posedge clk); #1; sync_in = 1'b0;
    check("t4_sync_rows", 64'(rows_received), 64'd0);
    send_row(32'h0000_C008, 3, 1'b0);
    check("t4_seq_ok", 64'(err_sequence), 64'd0);
    send_beat(32'h0000_C00A, 1'b0, 1'b0, 1'b0);
    check("t4_seq_set", 64'(err_sequence), 64'd1);
    send_beat(32'hF000_0001, 1'b0, 1'b0, 1'b0);
    send_beat(32'hF000_0002, 1'b0, 1'b0, 1'b0);
    send_beat(32'hF000_0003, 1'b1, 1'b0, 1'b0);
    pulse_clear();
    send_row(32'h0000_C00B, 3, 1'b0);
    check("t4_seq_once", 64'(err_sequence), 64'd0);
    check("t4_rows", 64'(rows_received), 64'd3);
    check("t4_framing", 64'(err_framing), 64'd0);

    // 5: simultaneous events
    send_row(32'h0000_C00C, 3, 1'b1);
    check("t5_sync_pulse", 64'(row_complete), 64'd1);
    check("t5_sync_rows", 64'(rows_received), 64'd0);
    send_beat(32'h0000_C008, 1'b0, 1'b0, 1'b0);
    send_beat(32'hF000_0001, 1'b1, 1'b0, 1'b1);
    check("t5_clr_vs_err", 64'(err_framing), 64'd1);
    check("t5_seq", 64'(err_sequence), 64'd0);

    // 6: reset mid-row with the buffer full
    @(posedge clk); #1;
    tx_tready = 1'b0;
    send_beat(32'h0000_C009, 1'b0, 1'b0, 1'b0);
    send_beat(32'hF000_0001, 1'b0, 1'b0, 1'b0);
    check("t6_full", 64'(rx_tready), 64'd0);
    reset = 1'b1;
    #1;
    check("t6_rst_ready_valid", 64'({rx_tready, tx_tvalid, tx_tlast}), 64'd0);
    check("t6_rst_data", 64'(tx_tdata), 64'd0);
    check("t6_rst_flags", 64'({row_complete, err_framing, err_sequence}), 64'd0);
    check("t6_rst_rows", 64'(rows_received), 64'd0);
    exp_q.delete();
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("t6_ready_back", 64'(rx_tready), 64'd1);
    tx_tready = 1'b1;
    send_row(32'h0000_C008, 3, 1'b0);
    check("t6_pulse", 64'(row_complete), 64'd1);
    check("t6_rows", 64'(rows_received), 64'd1);
    check("t6_errs", 64'({err_framing, err_sequence}), 64'd0);
    repeat (3) @(posedge clk); #1;
    check("final_drained", 64'(exp_q.size()), 64'd0);
    check("final_pulses", 64'(pulse_cnt), 64'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
